// File: rtl/temp_bcd_convert.sv
// Converts a raw temperature sensor sample into a sign plus four BCD digits (hundreds, tens, ones, tenths).
// The binary-to-BCD step runs sequentially with double-dabble, one shift per clock.
module temp_bcd_convert #(
  parameter bit SIXTEEN_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] msb,
  input  logic [7:0] lsb,
  output logic       busy,
  output logic       done,
  output logic       valid,
  output logic       negative,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic [3:0] bcd_tenth
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          RND_SHIFT = SIXTEEN_BIT ? 7 : 4;
  localparam logic [20:0] RND_ADD   = SIXTEEN_BIT ? 21'd64 : 21'd8;

  state_t      state_q, state_d;
  logic [11:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        neg_pend_q, neg_pend_d;
  logic [15:0] digits_q, digits_d;
  logic        negative_q, negative_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;

  logic [15:0] raw_word;
  logic [15:0] raw_ext;
  logic        raw_sign;
  logic [16:0] mag;
  logic [20:0] prod;
  logic [11:0] tenths;
  logic [15:0] bcd_adj;

  // 13-bit samples are left-justified in the register pair, so shift right arithmetically.
  always_comb begin
    raw_word = {msb, lsb};
    raw_sign = raw_word[15];
    raw_ext  = SIXTEEN_BIT ? raw_word : {{3{raw_word[15]}}, raw_word[15:3]};
    mag      = raw_sign ? (17'd0 - {raw_ext[15], raw_ext}) : {1'b0, raw_ext};
    prod     = {4'd0, mag} * 21'd10 + RND_ADD;
    tenths   = 12'(prod >> RND_SHIFT);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? (bcd_q[i*4 +: 4] + 4'd3)
                                                   : bcd_q[i*4 +: 4];
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    neg_pend_d = neg_pend_q;
    digits_d   = digits_q;
    negative_d = negative_q;
    done_d     = 1'b0;
    valid_d    = valid_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d      = tenths;
          bcd_d      = 16'd0;
          cnt_d      = 4'd0;
          neg_pend_d = raw_sign && (tenths != 12'd0);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'd11) begin
          state_d = DONE;
        end
      end
      DONE: begin
        digits_d   = bcd_q;
        negative_d = neg_pend_q;
        done_d     = 1'b1;
        valid_d    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bin_q      <= 12'd0;
      bcd_q      <= 16'd0;
      cnt_q      <= 4'd0;
      neg_pend_q <= 1'b0;
      digits_q   <= 16'd0;
      negative_q <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      neg_pend_q <= neg_pend_d;
      digits_q   <= digits_d;
      negative_q <= negative_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign valid     = valid_q;
  assign negative  = negative_q;
  assign bcd_hund  = digits_q[15:12];
  assign bcd_tens  = digits_q[11:8];
  assign bcd_ones  = digits_q[7:4];
  assign bcd_tenth = digits_q[3:0];

endmodule

// File: tb/tb_temp_bcd_convert.sv
// Directed and reference-model checks of temp_bcd_convert in both 13-bit and 16-bit sensor modes.
module tb_temp_bcd_convert;

  logic       clk = 1'b0;
  logic       reset;
  logic       start13, start16;
  logic [7:0] msb_i, lsb_i;

  logic       busy13, done13, valid13, neg13;
  logic [3:0] h13, t13, o13, f13;
  logic       busy16, done16, valid16, neg16;
  logic [3:0] h16, t16, o16, f16;

  temp_bcd_convert #(.SIXTEEN_BIT(1'b0)) u_dut13 (
    .clk(clk), .reset(reset), .start(start13), .msb(msb_i), .lsb(lsb_i),
    .busy(busy13), .done(done13), .valid(valid13), .negative(neg13),
    .bcd_hund(h13), .bcd_tens(t13), .bcd_ones(o13), .bcd_tenth(f13)
  );

  temp_bcd_convert #(.SIXTEEN_BIT(1'b1)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .msb(msb_i), .lsb(lsb_i),
    .busy(busy16), .done(done16), .valid(valid16), .negative(neg16),
    .bcd_hund(h16), .bcd_tens(t16), .bcd_ones(o16), .bcd_tenth(f16)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        mode;
  logic        s_busy, s_done, s_valid, s_neg;
  logic [15:0] s_dig;

  always_comb begin
    if (mode) begin
      s_busy = busy16; s_done = done16; s_valid = valid16; s_neg = neg16;
      s_dig  = {h16, t16, o16, f16};
    end else begin
      s_busy = busy13; s_done = done13; s_valid = valid13; s_neg = neg13;
      s_dig  = {h13, t13, o13, f13};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: rounding formula on the magnitude, then decimal digits by division.
  function automatic logic [16:0] ref_conv(input logic m16, input logic [7:0] m, input logic [7:0] l);
    int raw, mag, t;
    logic [15:0] dig;
    raw = $signed({m, l});
    if (!m16) raw = raw >>> 3;
    mag = (raw < 0) ? -raw : raw;
    t   = m16 ? ((mag * 10 + 64) >>> 7) : ((mag * 10 + 8) >>> 4);
    dig = {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
    return {(raw < 0) && (t != 0), dig};
  endfunction

  task automatic launch(input logic m16, input logic [7:0] m, input logic [7:0] l);
    @(negedge clk);
    mode  = m16;
    msb_i = m;
    lsb_i = l;
    if (m16) start16 = 1'b1; else start13 = 1'b1;
    @(posedge clk);
    #1;
    start13 = 1'b0;
    start16 = 1'b0;
    msb_i   = ~m;
    lsb_i   = ~l;
  endtask

  task automatic convert(input string tag, input logic m16, input logic [7:0] m, input logic [7:0] l,
                         input logic [15:0] exp_dig, input logic exp_neg);
    int lat;
    launch(m16, m, l);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!s_done && lat < 40);
    check({tag, "_latency"}, lat, 13);
    check({tag, "_digits"}, s_dig, exp_dig);
    check({tag, "_negative"}, s_neg, exp_neg);
    check({tag, "_valid"}, s_valid, 1'b1);
    check({tag, "_busy_in_done"}, s_busy, 1'b0);
    @(posedge clk);
    #1;
    check({tag, "_done_drops"}, s_done, 1'b0);
  endtask

  initial begin
    int          ndone;
    logic [15:0] last_dig;
    logic [16:0] r;
    logic [7:0]  rm, rl;

    reset = 1'b1; start13 = 1'b0; start16 = 1'b0; mode = 1'b0;
    msb_i = 8'h00; lsb_i = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done13 || done16) ndone++;
    end
    check("idle_no_done", ndone, 0);
    check("idle_outputs13", {busy13, valid13, neg13, h13, t13, o13, f13}, 19'd0);
    check("idle_outputs16", {busy16, valid16, neg16, h16, t16, o16, f16}, 19'd0);

    convert("m13_25p0",   1'b0, 8'h0C, 8'h80, 16'h0250, 1'b0);
    convert("m13_neg10",  1'b0, 8'hFA, 8'hF8, 16'h0101, 1'b1);
    convert("m13_min",    1'b0, 8'h80, 8'h00, 16'h2560, 1'b1);
    convert("m13_150",    1'b0, 8'h4B, 8'h00, 16'h1500, 1'b0);
    convert("m13_lsb1",   1'b0, 8'h00, 8'h08, 16'h0001, 1'b0);
    convert("m13_lsb3",   1'b0, 8'h00, 8'h18, 16'h0002, 1'b0);
    convert("m13_zero",   1'b0, 8'h00, 8'h00, 16'h0000, 1'b0);

    // Second start arriving at edge 5 must be dropped.
    launch(1'b0, 8'h0C, 8'h80);
    repeat (4) @(posedge clk);
    @(negedge clk);
    msb_i = 8'h4B; lsb_i = 8'h00; start13 = 1'b1;
    @(posedge clk);
    #1;
    start13 = 1'b0;
    ndone = 0;
    last_dig = 16'hFFFF;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done13) begin
        ndone++;
        last_dig = s_dig;
      end
    end
    check("busy_start_done_count", ndone, 1);
    check("busy_start_digits", last_dig, 16'h0250);
    check("busy_start_idle", busy13, 1'b0);

    // Reset at edge 6 aborts the conversion and clears the outputs.
    launch(1'b0, 8'hFA, 8'hF8);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_done", done13, 1'b0);
    check("abort_outputs", {busy13, valid13, neg13, h13, t13, o13, f13}, 19'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done13) ndone++;
    end
    check("abort_no_done", ndone, 0);
    convert("after_abort", 1'b0, 8'h0C, 8'h80, 16'h0250, 1'b0);

    convert("m16_25p0",    1'b1, 8'h0C, 8'h80, 16'h0250, 1'b0);
    convert("m16_min",     1'b1, 8'h80, 8'h00, 16'h2560, 1'b1);
    convert("m16_negzero", 1'b1, 8'hFF, 8'hFF, 16'h0000, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rm = 8'($urandom);
      rl = 8'($urandom);
      r  = ref_conv(i[0], rm, rl);
      convert(i[0] ? "rand16" : "rand13", i[0], rm, rl, r[15:0], r[16]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/temp_bcd_convert.md
Name: temp_bcd_convert

Overview:
Downstream consumer of the temperature-sensor readout. It takes the raw MSB/LSB pair produced by the sensor-control FSM after each I2C read and converts it sequentially, using double-dabble, into sign plus four BCD digits (hundreds, tens, ones, tenths of °C). Its outputs feed the 7-segment display driver directly. It replaces raw-hex display of the sensor registers.

Parameters:
SIXTEEN_BIT, 0, 0 = sensor in 13-bit mode (raw = {msb,lsb}[15:3], 1/16 °C per LSB); 1 = 16-bit mode (raw = {msb,lsb}, 1/128 °C per LSB)

Ports:
clk  input  1  system clock (the divided display/I2C clock)
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: msb/lsb hold a new sample
msb  input  8  sensor temperature MSB register
lsb  input  8  sensor temperature LSB register
busy  output  1  conversion in progress; start ignored while high
done  output  1  one-cycle pulse: digit outputs just updated
valid  output  1  at least one conversion completed since reset
negative  output  1  displayed value is below zero
bcd_hund  output  4  hundreds digit
bcd_tens  output  4  tens digit
bcd_ones  output  4  ones digit
bcd_tenth  output  4  tenths digit

Behaviour:
- One clock; reset is synchronous and active-high. All state updates occur on posedge clk.
- Reset: state IDLE. busy, done, valid and negative are 0. All digit outputs are 0. Reset mid-conversion aborts the conversion with no done pulse and clears all outputs.
- Arithmetic:
  - raw is two's complement: 13-bit (SIXTEEN_BIT=0) or 16-bit.
  - mag = |raw|, width raw+1 bits, so -4096 and -32768 are handled exactly.
  - Tenths value t:
    - SIXTEEN_BIT=0: t = (mag*10 + 8) >> 4.
    - SIXTEEN_BIT=1: t = (mag*10 + 64) >> 7.
    - Rounding is half-up on the magnitude. Internal product is at least 20 bits.
  - Maximum t is 2560, which fits in 12 bits. No saturation is required.
  - negative = raw sign AND (t != 0). There is no negative zero.
- FSM states:
  - IDLE: if start=1, latch msb/lsb, compute t, load the 12-bit shift register with t, clear the 16-bit BCD accumulator, clear the iteration counter, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: once per cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd,bin} left by 1. Counter increments. After the 12th shift, go to DONE.
  - DONE: register the BCD nibbles and negative into the outputs, set done=1 and valid=1, and go to IDLE.
- Timing:
  - Let start be sampled at edge 0.
  - SHIFT occupies edges 1–12. DONE is the state after edge 12.
  - Outputs update at edge 13. done is high for the cycle after edge 13; state is IDLE in that cycle.
  - Latency from start sample to new outputs: 13 edges.
- busy = (state != IDLE). It is high from after edge 0 through the cycle after edge 12.
- start while busy is dropped; there is no queuing.
- start in the same cycle that done is high is accepted.
- start held high for several cycles re-triggers once per return to IDLE.
- msb/lsb may change after the start sample without affecting the conversion in progress.
- Outputs hold their last values between conversions. There is no intermediate glitching; digits change only at the DONE edge.
- Digit values are always 0–9, and bcd_hund ≤ 2.

Test Plan:
- Reset, then idle 20 cycles -> all outputs 0, busy=0, valid=0, no done.
- SIXTEEN_BIT=0, msb=0x0C lsb=0x80, start pulse -> done exactly 13 edges later; digits 0,2,5,0; negative=0; valid=1.
- SIXTEEN_BIT=0, msb=0xFA lsb=0xF8 (-10.0625 °C) -> digits 0,1,0,1; negative=1. Then msb=0x80 lsb=0x00 -> digits 2,5,6,0; negative=1.
- SIXTEEN_BIT=0, sweep: 0x4B00 -> 1,5,0,0; 0x0008 -> 0,0,0,1; 0x0018 -> 0,0,0,2; 0x0000 -> 0,0,0,0 with negative=0. Also a second start pulse at edge 5 of a conversion -> ignored, only one done.
- Reset asserted at edge 6 of a conversion -> no done; outputs 0 the cycle after. A start after release converts normally.
- SIXTEEN_BIT=1, msb=0x0C lsb=0x80 -> digits 0,2,5,0. msb=0x80 lsb=0x00 -> 2,5,6,0 with negative=1. Random 13-bit and 16-bit values checked against a reference model of the rounding formula.
